// File: rtl/sky130_sram_1rw1r_param.sv
// 1RW + 1R single-clock SRAM model with lane write mask, defined same-address
// collision behaviour, held outputs and an optional reset-triggered fill sweep.
module sky130_sram_1rw1r_param #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           WMASK_WIDTH    = 8,
   parameter int unsigned           ADDR_WIDTH     = 8,
   parameter int unsigned           COLLISION_MODE = 1,
   parameter int unsigned           INIT_ON_RESET  = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
   localparam int unsigned          NUM_WMASKS     = DATA_WIDTH / WMASK_WIDTH,
   localparam int unsigned          RAM_DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk0,
   input  logic                  rstb0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  init_busy,
   output logic                  collision
);

   typedef enum logic {StInit, StRun} state_e;

   localparam state_e ResetState = (INIT_ON_RESET != 0) ? StInit : StRun;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
   logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
   logic                  collision_q, collision_d;

   logic [DATA_WIDTH-1:0] bit_mask;
   logic [DATA_WIDTH-1:0] rd0_word, rd1_word, merged1;
   logic                  run, wr_en, rd0_en, rd1_en, hit;

   always_comb begin
      bit_mask = '0;
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
         bit_mask[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{wmask0[i]}};
      end
   end

   assign run    = (state_q == StRun);
   assign wr_en  = run & ~csb0 & ~web0 & (|wmask0);
   assign rd0_en = run & ~csb0 & web0;
   assign rd1_en = run & ~csb1;
   assign hit    = wr_en & rd1_en & (addr0 == addr1);

   assign rd0_word = mem[addr0];
   assign rd1_word = mem[addr1];
   // Write-first view of port 1's word: new lanes where masked, old elsewhere.
   assign merged1  = (rd1_word & ~bit_mask) | (din0 & bit_mask);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dout0_d     = dout0_q;
      dout1_d     = dout1_q;
      collision_d = 1'b0;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (rd0_en) begin
               dout0_d = rd0_word;
            end
            if (rd1_en) begin
               dout1_d = (hit && (COLLISION_MODE != 0)) ? merged1 : rd1_word;
            end
            collision_d = hit;
         end
      endcase
   end

   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         state_q     <= ResetState;
         cnt_q       <= '0;
         dout0_q     <= '0;
         dout1_q     <= '0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dout0_q     <= dout0_d;
         dout1_q     <= dout1_d;
         collision_q <= collision_d;
      end
   end

   // Storage has no reset; only the sweep or port 0 rewrites it.
   always_ff @(posedge clk0) begin
      if (state_q == StInit) begin
         mem[cnt_q] <= INIT_VALUE;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               mem[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
         end
      end
   end

   assign dout0     = dout0_q;
   assign dout1     = dout1_q;
   assign collision = collision_q;
   assign init_busy = (state_q == StInit);

endmodule
